seg7_frame_monitor: RTL

//  Receive side of the 7-segment animation output. Samples a 7-bit segment bus (e.g. another

---
 rtl/seg7_frame_monitor_pkg.sv | 41 ++++
 rtl/seg7_inv_decode.sv | 44 ++++
 rtl/seg7_frame_monitor.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/seg7_frame_monitor_pkg.sv
// ---------------------------------------------------------------------------
// seg7_frame_monitor_pkg
//   Shared definitions for the 7-segment frame monitor:
//   - segment bus bit order: bit0=a, bit1=b, ... bit6=g, active high
//   - the sixteen hex glyphs as drawn by the animation driver
//   - the frame monitor FSM state encoding (2 bits)
// ---------------------------------------------------------------------------
package seg7_frame_monitor_pkg;

    localparam int SEG_W = 7;

    typedef logic [SEG_W-1:0] seg_t;

    // Hex glyphs, segments g..a from MSB to LSB.
    localparam seg_t SEG_HEX_0 = 7'h3F;
    localparam seg_t SEG_HEX_1 = 7'h06;
    localparam seg_t SEG_HEX_2 = 7'h5B;
    localparam seg_t SEG_HEX_3 = 7'h4F;
    localparam seg_t SEG_HEX_4 = 7'h66;
    localparam seg_t SEG_HEX_5 = 7'h6D;
    localparam seg_t SEG_HEX_6 = 7'h7D;
    localparam seg_t SEG_HEX_7 = 7'h07;
    localparam seg_t SEG_HEX_8 = 7'h7F;
    localparam seg_t SEG_HEX_9 = 7'h6F;
    localparam seg_t SEG_HEX_A = 7'h77;
    localparam seg_t SEG_HEX_B = 7'h7C;
    localparam seg_t SEG_HEX_C = 7'h39;
    localparam seg_t SEG_HEX_D = 7'h5E;
    localparam seg_t SEG_HEX_E = 7'h79;
    localparam seg_t SEG_HEX_F = 7'h71;

    // ST_WAIT_FIRST : nothing accepted since reset / clear
    // ST_SETTLE     : candidate differs from the last accepted frame
    // ST_HOLD       : candidate equals the last accepted frame
    typedef enum logic [1:0] {
        ST_WAIT_FIRST = 2'd0,
        ST_SETTLE     = 2'd1,
        ST_HOLD       = 2'd2
    } mon_state_e;

endpackage

// File: rtl/seg7_inv_decode.sv
// ---------------------------------------------------------------------------
// seg7_inv_decode
//   Combinational inverse 7-segment decoder: maps a segment pattern back to
//   the hex digit it draws.
// Ports:
//   seg        in   7  segment pattern, bit0=a .. bit6=g
//   hex_val    out  4  decoded digit, 0 when seg is not a hex glyph
//   hex_valid  out  1  seg is one of the sixteen hex glyphs
// ---------------------------------------------------------------------------
module seg7_inv_decode
    import seg7_frame_monitor_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output logic [3:0]       hex_val,
    output logic             hex_valid
);

    // NOTE: every output of an always_comb block gets a default before the
    // case so that no path leaves it unassigned (which would infer a latch).
    always_comb begin
        hex_val   = 4'h0;
        hex_valid = 1'b1;
        case (seg)
            SEG_HEX_0: hex_val = 4'h0;
            SEG_HEX_1: hex_val = 4'h1;
            SEG_HEX_2: hex_val = 4'h2;
            SEG_HEX_3: hex_val = 4'h3;
            SEG_HEX_4: hex_val = 4'h4;
            SEG_HEX_5: hex_val = 4'h5;
            SEG_HEX_6: hex_val = 4'h6;
            SEG_HEX_7: hex_val = 4'h7;
            SEG_HEX_8: hex_val = 4'h8;
            SEG_HEX_9: hex_val = 4'h9;
            SEG_HEX_A: hex_val = 4'hA;
            SEG_HEX_B: hex_val = 4'hB;
            SEG_HEX_C: hex_val = 4'hC;
            SEG_HEX_D: hex_val = 4'hD;
            SEG_HEX_E: hex_val = 4'hE;
            SEG_HEX_F: hex_val = 4'hF;
            default:   hex_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_frame_monitor.sv
// ---------------------------------------------------------------------------
// seg7_frame_monitor
//   Receive side of the 7-segment animation output. Synchronises an
//   asynchronous segment bus, waits for a pattern to hold still for
//   STABLE_CYCLES clocks, then accepts it as a frame: decodes it to a hex
//   digit, counts it, and measures the clocks since the previous frame.
// Parameters:
//   STABLE_CYCLES  clocks a synchronised pattern must hold before acceptance (>=2)
//   PERIOD_BIT     width of the frame-period counter
//   CNT_BIT        width of the accepted-frame counter
// Ports:
//   clk           in   1           system clock
//   rst_n         in   1           asynchronous active-low reset
//   ena           in   1           1 = monitor active, 0 = synchronous clear
//   seg_in        in   7           segment bus, bit0=a .. bit6=g, asynchronous
//   frame_stb     out  1           one-cycle pulse per accepted frame
//   frame_seg     out  7           last accepted pattern
//   hex_val       out  4           hex digit of frame_seg (0 if not a glyph)
//   hex_valid     out  1           frame_seg is a hex glyph
//   period        out  PERIOD_BIT  clocks between the last two strobes, saturating
//   period_valid  out  1           period holds a real measurement
//   frame_cnt     out  CNT_BIT     accepted frames since clear, wrapping
//   overflow      out  1           sticky: period counter saturated since clear
// ---------------------------------------------------------------------------
module seg7_frame_monitor
    import seg7_frame_monitor_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int PERIOD_BIT    = 25,
    parameter int CNT_BIT       = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [SEG_W-1:0]      seg_in,
    output logic                  frame_stb,
    output logic [SEG_W-1:0]      frame_seg,
    output logic [3:0]            hex_val,
    output logic                  hex_valid,
    output logic [PERIOD_BIT-1:0] period,
    output logic                  period_valid,
    output logic [CNT_BIT-1:0]    frame_cnt,
    output logic                  overflow
);

    localparam int                    STAB_W   = $clog2(STABLE_CYCLES);
    localparam logic [STAB_W-1:0]     STAB_MAX = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [PERIOD_BIT-1:0] PER_MAX  = '1;

    logic [SEG_W-1:0]      s1, s2;
    logic [SEG_W-1:0]      cand;
    logic [STAB_W-1:0]     stab_cnt;
    logic [PERIOD_BIT-1:0] per_cnt;
    logic [PERIOD_BIT-1:0] per_sat_inc;
    mon_state_e            state, state_d;
    logic                  cand_stable;
    logic                  accept;
    logic [3:0]            dec_val;
    logic                  dec_valid;

    // Two-flop synchroniser; keeps running while ena is low so that the
    // pipeline is already filled when the monitor is re-enabled.
    // NOTE: all sequential state is written with non-blocking assignments so
    // every flop samples the pre-edge value of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= seg_in;
            s2 <= s1;
        end
    end

    // Stability tracking. cand follows s2 even while disabled; the counter
    // only advances while enabled and saturates so a long hold stays armed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand     <= '0;
            stab_cnt <= '0;
        end else if (s2 != cand) begin
            cand     <= s2;
            stab_cnt <= '0;
        end else if (!ena) begin
            stab_cnt <= '0;
        end else if (stab_cnt != STAB_MAX) begin
            stab_cnt <= stab_cnt + 1'b1;
        end
    end

    assign cand_stable = (s2 == cand) && (stab_cnt == STAB_MAX);

    // cand always takes the value of s2 on the next edge, so s2 is compared
    // directly with frame_seg to decide between SETTLE and HOLD.
    always_comb begin
        state_d = state;
        accept  = 1'b0;
        if (!ena) begin
            state_d = ST_WAIT_FIRST;
        end else begin
            case (state)
                ST_WAIT_FIRST: begin
                    if (cand_stable) begin
                        accept  = 1'b1;
                        state_d = ST_HOLD;
                    end
                end
                ST_SETTLE: begin
                    if (cand_stable) begin
                        accept  = 1'b1;
                        state_d = ST_HOLD;
                    end else if (s2 == frame_seg) begin
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (s2 != frame_seg) state_d = ST_SETTLE;
                end
                default: state_d = ST_WAIT_FIRST;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_WAIT_FIRST;
        else        state <= state_d;
    end

    // Decoding cand lets hex_val/hex_valid be registered in the same edge as
    // frame_seg.
    seg7_inv_decode u_decode (
        .seg       (cand),
        .hex_val   (dec_val),
        .hex_valid (dec_valid)
    );

    // Accepted-frame registers hold their value across a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_stb <= 1'b0;
            frame_seg <= '0;
            hex_val   <= '0;
            hex_valid <= 1'b0;
        end else begin
            frame_stb <= accept;
            if (accept) begin
                frame_seg <= cand;
                hex_val   <= dec_val;
                hex_valid <= dec_valid;
            end
        end
    end

    assign per_sat_inc = (per_cnt == PER_MAX) ? PER_MAX : per_cnt + 1'b1;

    // Period and frame counters. per_cnt holds (clocks since last accept - 1)
    // at the accepting edge, hence the +1 when it is latched into period.
    // Acceptance outside ST_WAIT_FIRST means a previous frame exists since
    // the last clear, so only then is the period meaningful.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt      <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            frame_cnt    <= '0;
            overflow     <= 1'b0;
        end else if (!ena) begin
            per_cnt      <= '0;
            period_valid <= 1'b0;
            frame_cnt    <= '0;
            overflow     <= 1'b0;
        end else begin
            if (per_cnt == PER_MAX) overflow <= 1'b1;
            if (accept) begin
                per_cnt   <= '0;
                frame_cnt <= frame_cnt + 1'b1;
                if (state != ST_WAIT_FIRST) begin
                    period       <= per_sat_inc;
                    period_valid <= 1'b1;
                end
            end else begin
                per_cnt <= per_sat_inc;
            end
        end
    end

endmodule
